// File: rtl/shift_feeder.sv
// Byte FIFO feeding a 74hc595 shift driver through a start/ready handshake.
// Optional dropped-write counter is built when SHIFT_FEEDER_OVF_CNT_EN is defined.
module shift_feeder #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_Rst_n,
    input  logic [7:0] i_Wr_Data,
    input  logic       i_Wr_En,
    output logic       o_Full,
    output logic       o_Empty,
    output logic [4:0] o_Level,
    output logic [7:0] o_Data,
    output logic       o_Enable,
    input  logic       i_Ready,
    output logic       o_Busy,
    output logic       o_Ovf,
    output logic [7:0] o_Ovf_Cnt
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [7:0]    mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    logic          full_q, empty_q;
    logic [7:0]    data_q;
    logic          enable_q, busy_q, ovf_q;
    logic          pop_s, push_s, drop_s;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        pop_s    = (state_q == ISSUE);
        push_s   = i_Wr_En && (!full_q || pop_s);
        drop_s   = i_Wr_En && full_q && !pop_s;
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty_q && i_Ready) state_d = ISSUE;
                else                     state_d = IDLE;
            end
            ISSUE:   state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!i_Ready) state_d = WAIT_DONE;
                else          state_d = WAIT_BUSY;
            end
            WAIT_DONE: begin
                if (i_Ready) state_d = IDLE;
                else         state_d = WAIT_DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_Wr_Data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_Rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 5'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            data_q   <= 8'h00;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == DEPTH_L);
            empty_q  <= (level_d == 5'd0);
            enable_q <= (state_d == ISSUE);
            busy_q   <= (state_d != IDLE);
            if (state_d == ISSUE) begin
                data_q <= mem_q[rd_ptr_q];
            end
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef SHIFT_FEEDER_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    // Saturating count of writes lost to a full FIFO.
    always_ff @(posedge i_clk) begin
        if (!i_Rst_n) begin
            ovf_cnt_q <= 8'h00;
        end else if (drop_s && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign o_Ovf_Cnt = ovf_cnt_q;
`else
    assign o_Ovf_Cnt = 8'h00;
`endif

    assign o_Full   = full_q;
    assign o_Empty  = empty_q;
    assign o_Level  = level_q;
    assign o_Data   = data_q;
    assign o_Enable = enable_q;
    assign o_Busy   = busy_q;
    assign o_Ovf    = ovf_q;

endmodule

// File: tb/tb_shift_feeder.sv
// Randomized self-checking bench for shift_feeder: queue-based reference model plus a
// behavioural 74hc595 driver that drops ready the cycle after accepting a start.
module tb_shift_feeder;

    localparam int DEPTH = 8;
`ifdef SHIFT_FEEDER_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_Rst_n;
    logic [7:0] i_Wr_Data;
    logic       i_Wr_En;
    logic       o_Full, o_Empty;
    logic [4:0] o_Level;
    logic [7:0] o_Data;
    logic       o_Enable;
    logic       i_Ready;
    logic       o_Busy, o_Ovf;
    logic [7:0] o_Ovf_Cnt;

    shift_feeder #(.DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_Rst_n(i_Rst_n), .i_Wr_Data(i_Wr_Data), .i_Wr_En(i_Wr_En),
        .o_Full(o_Full), .o_Empty(o_Empty), .o_Level(o_Level), .o_Data(o_Data),
        .o_Enable(o_Enable), .i_Ready(i_Ready), .o_Busy(o_Busy), .o_Ovf(o_Ovf),
        .o_Ovf_Cnt(o_Ovf_Cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [7:0] mq[$];
    bit         m_ovf     = 1'b0;
    int         m_cnt     = 0;
    logic [7:0] last_data = 8'h00;
    bit         prev_en   = 1'b0;
    bit         prev_rdy  = 1'b1;
    logic [7:0] log_data[$];
    int         log_cyc[$];

    bit hold     = 1'b0;
    int drv_busy = 0;
    int busy_min = 1;
    int busy_max = 4;
    bit drv_ok   = 1'b1;
    bit seen_low = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check this cycle's outputs, drive inputs, advance the model.
    task automatic step(input bit wr, input logic [7:0] d, input bit rst);
        bit pop;
        bit rdy;
        bit acc;
        bit drop;
        check("level", 32'(o_Level), 32'(mq.size()));
        check("full",  32'(o_Full),  32'(mq.size() == DEPTH));
        check("empty", 32'(o_Empty), 32'(mq.size() == 0));
        check("ovf",   32'(o_Ovf),   32'(m_ovf));
        check("ovfcnt", 32'(o_Ovf_Cnt), 32'(m_cnt));
        pop = (o_Enable === 1'b1);
        if (pop) begin
            check("issue_nonempty", 32'(mq.size() != 0), 32'd1);
            if (mq.size() != 0) check("issue_data", 32'(o_Data), 32'(mq[0]));
            check("issue_ready", 32'(prev_rdy), 32'd1);
            check("issue_drv_cycled", 32'(drv_ok), 32'd1);
            check("issue_busy", 32'(o_Busy), 32'd1);
            check("single_pulse", 32'(prev_en), 32'd0);
            log_data.push_back(o_Data);
            log_cyc.push_back(cyc);
            last_data = o_Data;
        end else begin
            check("data_hold", 32'(o_Data), 32'(last_data));
        end
        prev_en = pop;

        if (drv_busy > 0) begin
            rdy = 1'b0;
            drv_busy--;
        end else begin
            rdy = pop ? 1'b1 : !hold;
        end
        if (pop) begin
            drv_busy = $urandom_range(busy_min, busy_max);
            drv_ok   = 1'b0;
            seen_low = 1'b0;
        end else if (!rdy) begin
            seen_low = 1'b1;
        end else if (seen_low) begin
            drv_ok = 1'b1;
        end
        prev_rdy = rdy;

        i_Ready   = rdy;
        i_Wr_En   = wr;
        i_Wr_Data = d;
        i_Rst_n   = !rst;

        if (rst) begin
            mq.delete();
            m_ovf     = 1'b0;
            m_cnt     = 0;
            last_data = 8'h00;
            prev_en   = 1'b0;
            drv_ok    = 1'b1;
        end else begin
            acc  = wr && ((mq.size() < DEPTH) || pop);
            drop = wr && (mq.size() == DEPTH) && !pop;
            if (pop && (mq.size() > 0)) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            if (drop) begin
                m_ovf = 1'b1;
                if (CNT_EN && (m_cnt < 255)) m_cnt++;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 1'b1);
        check("rst_enable", 32'(o_Enable), 32'd0);
        check("rst_busy",   32'(o_Busy),   32'd0);
        check("rst_data",   32'(o_Data),   32'h00);
        check("rst_level",  32'(o_Level),  32'd0);
        check("rst_empty",  32'(o_Empty),  32'd1);
        check("rst_full",   32'(o_Full),   32'd0);
        check("rst_ovf",    32'(o_Ovf),    32'd0);
        check("rst_ovfcnt", 32'(o_Ovf_Cnt), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int c0;
        int np;
        int base;
        bit seen;
        i_Rst_n = 1'b0; i_Wr_En = 1'b0; i_Wr_Data = 8'h00; i_Ready = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        do_reset();
        idle(2);

        // Single byte: start pulse two cycles after the write.
        c0 = cyc;
        np = log_cyc.size();
        step(1'b1, 8'hA5, 1'b0);
        idle(8);
        check("lat_pulses", 32'(log_cyc.size() - np), 32'd1);
        if (log_cyc.size() > np) begin
            check("lat_cycle", 32'(log_cyc[np] - c0), 32'd2);
            check("lat_data", 32'(log_data[np]), 32'hA5);
        end
        check("lat_level0", 32'(o_Level), 32'd0);

        // Fill with the driver held busy, then overflow twice.
        hold = 1'b1;
        np = log_cyc.size();
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        idle(2);
        check("fill_full", 32'(o_Full), 32'd1);
        check("fill_level", 32'(o_Level), 32'd8);
        check("fill_nopulse", 32'(log_cyc.size() - np), 32'd0);
        step(1'b1, 8'h09, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_set", 32'(o_Ovf), 32'd1);
        check("ovf_cnt2", 32'(o_Ovf_Cnt), CNT_EN ? 32'd2 : 32'd0);
        check("ovf_level", 32'(o_Level), 32'd8);

        // Release the driver; the 8 bytes drain in order.
        hold = 1'b0;
        for (int i = 0; i < 150 && (log_cyc.size() - np) < 8; i++) step(1'b0, 8'h00, 1'b0);
        check("drain_count", 32'(log_cyc.size() - np), 32'd8);
        for (int i = 0; i < 8 && (np + i) < log_data.size(); i++)
            check("drain_order", 32'(log_data[np + i]), 32'(i + 1));
        idle(8);

        // Full FIFO, write in the ISSUE cycle: accepted, no overflow.
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
        hold = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (o_Enable === 1'b1) seen = 1'b1;
            else step(1'b0, 8'h00, 1'b0);
        end
        check("full_issue_seen", 32'(seen), 32'd1);
        step(1'b1, 8'h5A, 1'b0);
        check("wrpop_level", 32'(o_Level), 32'd8);
        check("wrpop_full", 32'(o_Full), 32'd1);
        check("wrpop_ovf", 32'(o_Ovf), 32'd0);
        idle(60);

        // Reset during WAIT_DONE with 3 bytes queued.
        do_reset();
        busy_min = 6; busy_max = 6;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("wd_level3", 32'(o_Level), 32'd3);
        check("wd_busy", 32'(o_Busy), 32'd1);
        do_reset();
        base = log_cyc.size();
        idle(20);
        check("wd_no_pulse", 32'(log_cyc.size() - base), 32'd0);
        step(1'b1, 8'h3C, 1'b0);
        idle(6);
        check("wd_new_pulse", 32'(log_cyc.size() - base), 32'd1);
        busy_min = 1; busy_max = 4;

        // Random traffic with occasional resets and driver stalls.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 39) == 0) hold = !hold;
                step($urandom_range(0, 99) < 45, 8'($urandom), 1'b0);
            end
        end
        hold = 1'b0;
        idle(120);
        check("final_empty", 32'(o_Empty), 32'd1);
        check("final_idle", 32'(o_Busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
